// File: rtl/sc_down_life_counter_pkg.sv
// Shared definitions for the player-life down-counter: FSM state encoding
// and the default grace window length for a 50 MHz clock.
package sc_down_life_counter_pkg;

  typedef enum logic [1:0] {
    ALIVE    = 2'b00,
    GRACE    = 2'b01,
    GAMEOVER = 2'b10
  } life_state_e;

  // One second of invulnerability at 50 MHz.
  localparam int GRACE_CYCLES_50MHZ = 50_000_000;
  localparam int GRACE_WIDTH_50MHZ  = 26;

endpackage

// File: rtl/sc_down_life_counter_if.sv
// Request/status bundle between the game logic (master) and the life
// counter (slave). Request lines are active-low; events are falling edges.
interface sc_down_life_counter_if #(
  parameter int DATAWIDTH = 4
);
  logic                 SC_downLIFECOUNTER_load_InLow;
  logic                 SC_downLIFECOUNTER_hit_InLow;
  logic                 SC_downLIFECOUNTER_extralife_InLow;
  logic [DATAWIDTH-1:0] SC_downLIFECOUNTER_data_OutBUS;
  logic                 SC_downLIFECOUNTER_gameover_Out;
  logic                 SC_downLIFECOUNTER_grace_Out;
  logic                 SC_downLIFECOUNTER_hitack_Out;

  modport master (
    output SC_downLIFECOUNTER_load_InLow,
    output SC_downLIFECOUNTER_hit_InLow,
    output SC_downLIFECOUNTER_extralife_InLow,
    input  SC_downLIFECOUNTER_data_OutBUS,
    input  SC_downLIFECOUNTER_gameover_Out,
    input  SC_downLIFECOUNTER_grace_Out,
    input  SC_downLIFECOUNTER_hitack_Out
  );

  modport slave (
    input  SC_downLIFECOUNTER_load_InLow,
    input  SC_downLIFECOUNTER_hit_InLow,
    input  SC_downLIFECOUNTER_extralife_InLow,
    output SC_downLIFECOUNTER_data_OutBUS,
    output SC_downLIFECOUNTER_gameover_Out,
    output SC_downLIFECOUNTER_grace_Out,
    output SC_downLIFECOUNTER_hitack_Out
  );
endinterface

// File: rtl/sc_fall_edge_detect.sv
// Falling-edge detector for an active-low request line. The history flop
// resets to 1 so a line that is already low at reset release is not an event.
module sc_fall_edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic in_i,
  output logic event_o
);

  logic prev_q;

  // Remember the level sampled at the previous edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) prev_q <= 1'b1;
    else          prev_q <= in_i;
  end

  // High when the line was 1 last edge and is 0 now.
  assign event_o = prev_q & ~in_i;

endmodule

// File: rtl/sc_down_life_counter.sv
// Player-life manager: loads an initial count, removes a life per death,
// adds one per bonus (saturating), runs a grace window after each death and
// flags game-over when the count reaches zero.
module sc_down_life_counter
  import sc_down_life_counter_pkg::*;
#(
  parameter int DATAWIDTH    = 4,
  parameter int INIT_LIVES   = 3,
  parameter int MAX_LIVES    = 9,
  parameter int GRACE_CYCLES = GRACE_CYCLES_50MHZ,
  parameter int GRACE_WIDTH  = GRACE_WIDTH_50MHZ
) (
  input  logic                      SC_downLIFECOUNTER_CLOCK_50,
  input  logic                      SC_downLIFECOUNTER_RESET_InLow,
  sc_down_life_counter_if.slave     bus
);

  localparam logic [DATAWIDTH-1:0]   LIVES_INIT = DATAWIDTH'(INIT_LIVES);
  localparam logic [DATAWIDTH-1:0]   LIVES_MAX  = DATAWIDTH'(MAX_LIVES);
  localparam logic [DATAWIDTH-1:0]   LIVES_ONE  = DATAWIDTH'(1);
  localparam logic [GRACE_WIDTH-1:0] TIMER_LOAD = GRACE_WIDTH'(GRACE_CYCLES - 1);

  logic clk;
  logic rst_n;
  assign clk   = SC_downLIFECOUNTER_CLOCK_50;
  assign rst_n = SC_downLIFECOUNTER_RESET_InLow;

  logic hit_evt;
  logic extra_evt;

  sc_fall_edge_detect u_hit_edge (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .in_i    (bus.SC_downLIFECOUNTER_hit_InLow),
    .event_o (hit_evt)
  );

  sc_fall_edge_detect u_extra_edge (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .in_i    (bus.SC_downLIFECOUNTER_extralife_InLow),
    .event_o (extra_evt)
  );

  life_state_e            state_q, state_d;
  logic [DATAWIDTH-1:0]   lives_q, lives_d;
  logic [GRACE_WIDTH-1:0] timer_q, timer_d;
  logic                   hitack_q, hitack_d;
  logic                   gameover_q;
  logic                   grace_q;
  logic [DATAWIDTH-1:0]   lives_plus;

  // Saturating bonus increment, shared by ALIVE and GRACE.
  assign lives_plus = (lives_q >= LIVES_MAX) ? LIVES_MAX : lives_q + LIVES_ONE;

  // Next state, next lives, grace timer and hit acknowledge.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    timer_d  = timer_q;
    hitack_d = 1'b0;
    if (!bus.SC_downLIFECOUNTER_load_InLow) begin
      // Reload wins; events in this cycle are dropped.
      state_d = ALIVE;
      lives_d = LIVES_INIT;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (hit_evt) begin
            hitack_d = 1'b1;
            if (extra_evt) begin
              // Death and bonus cancel out, but the grace window still starts.
              state_d = GRACE;
              timer_d = TIMER_LOAD;
            end else if (lives_q > LIVES_ONE) begin
              lives_d = lives_q - LIVES_ONE;
              state_d = GRACE;
              timer_d = TIMER_LOAD;
            end else begin
              lives_d = '0;
              state_d = GAMEOVER;
            end
          end else if (extra_evt) begin
            lives_d = lives_plus;
          end
        end
        GRACE: begin
          if (extra_evt) lives_d = lives_plus;
          if (timer_q == '0) state_d = ALIVE;
          else               timer_d = timer_q - 1'b1;
        end
        GAMEOVER: begin
          lives_d = '0;
        end
        default: begin
          state_d = ALIVE;
          lives_d = LIVES_INIT;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, lives, timer and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ALIVE;
      lives_q    <= LIVES_INIT;
      timer_q    <= '0;
      hitack_q   <= 1'b0;
      gameover_q <= 1'b0;
      grace_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      timer_q    <= timer_d;
      hitack_q   <= hitack_d;
      gameover_q <= (state_d == GAMEOVER);
      grace_q    <= (state_d == GRACE);
    end
  end

  assign bus.SC_downLIFECOUNTER_data_OutBUS  = lives_q;
  assign bus.SC_downLIFECOUNTER_gameover_Out = gameover_q;
  assign bus.SC_downLIFECOUNTER_grace_Out    = grace_q;
  assign bus.SC_downLIFECOUNTER_hitack_Out   = hitack_q;

endmodule

// File: tb/tb_sc_down_life_counter.sv
// Directed bench for the life down-counter with a 4-clock grace window.
// Outputs are compared as {lives, gameover, grace, hitack}.
module tb_sc_down_life_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_n = 1'b1;
  logic hit_n = 1'b1;
  logic extra_n = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sc_down_life_counter_if #(.DATAWIDTH(4)) bus ();

  assign bus.SC_downLIFECOUNTER_load_InLow      = load_n;
  assign bus.SC_downLIFECOUNTER_hit_InLow       = hit_n;
  assign bus.SC_downLIFECOUNTER_extralife_InLow = extra_n;

  sc_down_life_counter #(
    .DATAWIDTH(4), .INIT_LIVES(3), .MAX_LIVES(5), .GRACE_CYCLES(4), .GRACE_WIDTH(3)
  ) dut (
    .SC_downLIFECOUNTER_CLOCK_50    (clk),
    .SC_downLIFECOUNTER_RESET_InLow (rst_n),
    .bus                            (bus)
  );

  logic [6:0] obs;
  assign obs = {bus.SC_downLIFECOUNTER_data_OutBUS, bus.SC_downLIFECOUNTER_gameover_Out,
                bus.SC_downLIFECOUNTER_grace_Out, bus.SC_downLIFECOUNTER_hitack_Out};

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; load_n = 1'b1; hit_n = 1'b1; extra_n = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;
  endtask

  // Each pulse is low for one edge; caller inspects outputs on return.
  task automatic pulse_hit();
    hit_n = 1'b0; @(negedge clk); hit_n = 1'b1;
  endtask

  task automatic pulse_extra();
    extra_n = 1'b0; @(negedge clk); extra_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== {4'd3, 3'b000}) begin
      tests_failed++; $display("FAIL reset_hold got=%h want=%h", obs, {4'd3, 3'b000});
    end
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(3);
    tests_run++;
    if (obs !== {4'd3, 3'b000}) begin
      tests_failed++; $display("FAIL reset_idle got=%h want=%h", obs, {4'd3, 3'b000});
    end
    $display("[TB] test_reset obs=%h", obs);
  endtask

  task automatic test_single_hit();
    int grace_cnt;
    int ack_cnt;
    do_reset();
    pulse_hit();
    tests_run++;
    if (obs !== {4'd2, 3'b011}) begin
      tests_failed++; $display("FAIL hit_first got=%h want=%h", obs, {4'd2, 3'b011});
    end
    grace_cnt = 1; ack_cnt = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.SC_downLIFECOUNTER_grace_Out) grace_cnt++;
      if (bus.SC_downLIFECOUNTER_hitack_Out) ack_cnt++;
    end
    tests_run++;
    if (grace_cnt !== 4) begin
      tests_failed++; $display("FAIL grace_len got=%0d want=4", grace_cnt);
    end
    tests_run++;
    if (ack_cnt !== 1) begin
      tests_failed++; $display("FAIL hitack_len got=%0d want=1", ack_cnt);
    end
    tests_run++;
    if (obs !== {4'd2, 3'b000}) begin
      tests_failed++; $display("FAIL hit_after got=%h want=%h", obs, {4'd2, 3'b000});
    end
    $display("[TB] test_single_hit grace=%0d acks=%0d obs=%h", grace_cnt, ack_cnt, obs);
  endtask

  task automatic test_hold_and_regrace();
    int ack_cnt;
    do_reset();
    ack_cnt = 0;
    hit_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.SC_downLIFECOUNTER_hitack_Out) ack_cnt++;
    end
    hit_n = 1'b1;
    wait_clks(2);
    tests_run++;
    if ({obs[6:3], ack_cnt[3:0]} !== {4'd2, 4'd1}) begin
      tests_failed++; $display("FAIL hold_low got lives=%0d acks=%0d want lives=2 acks=1", obs[6:3], ack_cnt);
    end
    do_reset();
    ack_cnt = 0;
    pulse_hit();
    if (bus.SC_downLIFECOUNTER_hitack_Out) ack_cnt++;
    @(negedge clk);
    pulse_hit();
    if (bus.SC_downLIFECOUNTER_hitack_Out) ack_cnt++;
    wait_clks(6);
    tests_run++;
    if ({obs[6:3], ack_cnt[3:0]} !== {4'd2, 4'd1}) begin
      tests_failed++; $display("FAIL hit_in_grace got lives=%0d acks=%0d want lives=2 acks=1", obs[6:3], ack_cnt);
    end
    $display("[TB] test_hold_and_regrace lives=%0d", obs[6:3]);
  endtask

  task automatic test_to_gameover();
    logic [6:0] exp [3];
    exp[0] = {4'd2, 3'b011};
    exp[1] = {4'd1, 3'b011};
    exp[2] = {4'd0, 3'b101};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse_hit();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++; $display("FAIL gameover_hit%0d got=%h want=%h", i, obs, exp[i]);
      end
      wait_clks(7);
    end
    hit_n = 1'b0; extra_n = 1'b0;
    @(negedge clk);
    hit_n = 1'b1; extra_n = 1'b1;
    wait_clks(1);
    tests_run++;
    if (obs !== {4'd0, 3'b100}) begin
      tests_failed++; $display("FAIL gameover_ignore got=%h want=%h", obs, {4'd0, 3'b100});
    end
    $display("[TB] test_to_gameover obs=%h", obs);
  endtask

  task automatic test_extralife();
    logic [3:0] exp_l [3];
    exp_l[0] = 4'd4; exp_l[1] = 4'd5; exp_l[2] = 4'd5;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse_extra();
      tests_run++;
      if (obs !== {exp_l[i], 3'b000}) begin
        tests_failed++; $display("FAIL extra%0d got=%h want=%h", i, obs, {exp_l[i], 3'b000});
      end
      wait_clks(1);
    end
    do_reset();
    pulse_hit();  wait_clks(7);
    pulse_hit();  wait_clks(7);
    tests_run++;
    if (obs !== {4'd1, 3'b000}) begin
      tests_failed++; $display("FAIL extra_setup got=%h want=%h", obs, {4'd1, 3'b000});
    end
    hit_n = 1'b0; extra_n = 1'b0;
    @(negedge clk);
    hit_n = 1'b1; extra_n = 1'b1;
    tests_run++;
    if (obs !== {4'd1, 3'b011}) begin
      tests_failed++; $display("FAIL hit_plus_extra got=%h want=%h", obs, {4'd1, 3'b011});
    end
    wait_clks(1);
    pulse_extra();
    tests_run++;
    if (obs !== {4'd2, 3'b010}) begin
      tests_failed++; $display("FAIL extra_in_grace got=%h want=%h", obs, {4'd2, 3'b010});
    end
    $display("[TB] test_extralife obs=%h", obs);
  endtask

  task automatic test_load_and_async_reset();
    do_reset();
    pulse_hit();  wait_clks(7);
    pulse_hit();  wait_clks(7);
    pulse_hit();  wait_clks(2);
    load_n = 1'b0;
    @(negedge clk);
    load_n = 1'b1;
    tests_run++;
    if (obs !== {4'd3, 3'b000}) begin
      tests_failed++; $display("FAIL load_gameover got=%h want=%h", obs, {4'd3, 3'b000});
    end
    load_n = 1'b0; hit_n = 1'b0;
    @(negedge clk);
    load_n = 1'b1;
    @(negedge clk);
    hit_n = 1'b1;
    tests_run++;
    if (obs !== {4'd3, 3'b000}) begin
      tests_failed++; $display("FAIL load_drops_hit got=%h want=%h", obs, {4'd3, 3'b000});
    end
    pulse_hit();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== {4'd3, 3'b000}) begin
      tests_failed++; $display("FAIL async_reset got=%h want=%h", obs, {4'd3, 3'b000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] test_load_and_async_reset obs=%h", obs);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_hold_and_regrace();
    test_to_gameover();
    test_extralife();
    test_load_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
